// File: rtl/axi_dmem_pkg.sv
// axi_dmem_pkg: shared constants and types for the DMEM line transfer engine.
// Holds the AXI encodings used on the HP port, the bus geometry, the line type
// and the engine state encoding.
package axi_dmem_pkg;

  localparam logic [2:0] AXI_BURST_INCR = 3'b001;
  localparam logic [2:0] AXI_BURST_WRAP = 3'b010;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int AXI_ADDR_W = 49;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 6;

  localparam int LINE_BYTES = 64;
  typedef logic [511:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_XFER = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } axi_dmem_state_e;

endpackage

// File: rtl/axi_dmem_line_master_if.sv
// MPSOC_S_AXI4_HP_bus: AXI4 bundle for the MPSOC HP slave port.
// 49-bit address, 64-bit data, 6-bit IDs, 3-bit (zero-extended) burst fields.
// Modports:
//   master - drives AR/AW/W channels and RREADY/BREADY
//   slave  - drives ARREADY/AWREADY/WREADY and the R/B channels
interface MPSOC_S_AXI4_HP_bus;
  import axi_dmem_pkg::*;

  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [2:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic                  aruser;
  logic                  arvalid;
  logic                  arready;

  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [AXI_ID_W-1:0]   awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [2:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic                  awuser;
  logic                  awvalid;
  logic                  awready;

  logic [AXI_DATA_W-1:0] wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [AXI_ID_W-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_dmem_line_master.sv
// axi_dmem_line_master: moves one cache line per request between the DMEM
// cache controller and the MPSOC HP port as a single BEATS-beat 64-bit burst.
//
// Ports:
//   ACLK, ARESETn      clock, asynchronous active-low reset
//   req_valid/ready    line request handshake (ready only in IDLE)
//   req_write          1 = writeback, 0 = refill
//   req_addr           byte address of the line
//   req_wdata          writeback line, beat i = [64*i +: 64]
//   resp_valid         one-cycle completion pulse
//   resp_rdata         refill line, held until the next refill completes
//   resp_err           error status, valid with resp_valid
//   axi                MPSOC_S_AXI4_HP_bus.master
//
// Build option AXI_DMEM_CRITICAL_WORD_EN: refills issue a WRAP burst starting
// at the requested word, and beat i lands in slot (req_addr[5:3] + i) mod BEATS.
// Without it refills are line-aligned INCR bursts with slot = beat index.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | ready for a request
// RD_ADDR  | AR presented, waiting for ARREADY
// RD_DATA  | collecting R beats, counter picks the slot
// WR_XFER  | AW and W streams in flight, either may finish first
// WR_RESP  | waiting for the B response
// DONE     | one-cycle resp_valid pulse
module axi_dmem_line_master
  import axi_dmem_pkg::*;
#(
  parameter int          BEATS      = 8,
  parameter logic [5:0]  AXI_ID     = 6'd0,
  parameter logic [3:0]  CACHE_ATTR = 4'b0011
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [48:0]           req_addr,
  input  logic [64*BEATS-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [64*BEATS-1:0]   resp_rdata,
  output logic                  resp_err,
  MPSOC_S_AXI4_HP_bus.master    axi
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_RD_ADDR = ST_RD_ADDR;
  localparam logic [2:0] S_RD_DATA = ST_RD_DATA;
  localparam logic [2:0] S_WR_XFER = ST_WR_XFER;
  localparam logic [2:0] S_WR_RESP = ST_WR_RESP;
  localparam logic [2:0] S_DONE    = ST_DONE;

  localparam int          CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST    = CW'(BEATS - 1);
  localparam logic [48:0] LINE_MASK = ~(49'(8 * BEATS) - 49'd1);
  localparam logic [48:0] WORD_MASK = ~49'h7;

  logic [2:0]          state_q;
  logic [CW-1:0]       cnt_q;
  logic [48:0]         addr_q;
  logic [64*BEATS-1:0] line_q;
  logic [64*BEATS-1:0] line_next;
  logic [64*BEATS-1:0] rdata_q;
  logic                err_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic [CW-1:0]       slot;
  logic                cnt_last;
  logic                aw_hs;
  logic                w_hs;

  assign cnt_last = (cnt_q == LAST);

`ifdef AXI_DMEM_CRITICAL_WORD_EN
  // addr_q keeps the requested word offset so the wrap start is known
  assign slot          = (addr_q[3 +: CW] + cnt_q) & LAST;
  assign axi.araddr    = addr_q;
  assign axi.arburst   = AXI_BURST_WRAP;
`else
  assign slot          = cnt_q;
  assign axi.araddr    = addr_q;
  assign axi.arburst   = AXI_BURST_INCR;
`endif

  // Refill beats are assembled in line_q (unused on reads) so resp_rdata
  // only changes when a refill completes.
  always_comb begin
    line_next = line_q;
    line_next[64*slot +: 64] = axi.rdata;
  end

  assign req_ready  = ARESETn && (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = AXI_SIZE_8B;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = CACHE_ATTR;
  assign axi.arprot  = 3'b000;
  assign axi.arqos   = 4'b0000;
  assign axi.aruser  = 1'b0;
  assign axi.arvalid = (state_q == S_RD_ADDR);
  assign axi.rready  = (state_q == S_RD_DATA);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q & LINE_MASK;
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.awsize  = AXI_SIZE_8B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = CACHE_ATTR;
  assign axi.awprot  = 3'b000;
  assign axi.awqos   = 4'b0000;
  assign axi.awuser  = 1'b0;
  assign axi.awvalid = (state_q == S_WR_XFER) && !aw_done_q;

  assign axi.wdata   = line_q[64*cnt_q +: 64];
  assign axi.wstrb   = 8'hFF;
  assign axi.wlast   = cnt_last;
  assign axi.wvalid  = (state_q == S_WR_XFER) && !w_done_q;
  assign axi.bready  = (state_q == S_WR_RESP);

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
`ifdef AXI_DMEM_CRITICAL_WORD_EN
            addr_q  <= req_write ? (req_addr & LINE_MASK) : (req_addr & WORD_MASK);
`else
            addr_q  <= req_addr & LINE_MASK;
`endif
            line_q    <= req_wdata;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= req_write ? S_WR_XFER : S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (axi.arready) state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (axi.rvalid) begin
            line_q <= line_next;
            if (axi.rresp != AXI_RESP_OKAY || axi.rid != AXI_ID || axi.rlast != cnt_last)
              err_q <= 1'b1;
            // the beat count, not RLAST, ends the burst
            if (cnt_last) begin
              rdata_q <= line_next;
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_WR_XFER: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs) begin
            if (cnt_last) w_done_q <= 1'b1;
            else          cnt_q    <= cnt_q + 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && cnt_last)))
            state_q <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (axi.bvalid) begin
            if (axi.bresp != AXI_RESP_OKAY || axi.bid != AXI_ID) err_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dmem_line_master.sv
module tb_axi_dmem_line_master;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [48:0]  req_addr = '0;
  logic [511:0] req_wdata = '0;
  logic         resp_valid;
  logic [511:0] resp_rdata;
  logic         resp_err;

  int n_vec = 0;
  int n_err = 0;

  MPSOC_S_AXI4_HP_bus axi();

  axi_dmem_line_master dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- reference model (AXI / line semantics) ----------------
  function automatic logic [48:0] exp_araddr(input logic [48:0] a);
`ifdef AXI_DMEM_CRITICAL_WORD_EN
    return a & ~49'h7;
`else
    return a & ~49'h3F;
`endif
  endfunction

  function automatic logic [2:0] exp_arburst();
`ifdef AXI_DMEM_CRITICAL_WORD_EN
    return 3'b010;
`else
    return 3'b001;
`endif
  endfunction

  // byte address of beat i of a 64-byte, 8x8-byte burst
  function automatic logic [48:0] beat_addr(input logic [48:0] a, input logic [2:0] burst, input int i);
    logic [48:0] base;
    base = a & ~49'h3F;
    if (burst == 3'b010) return base | ((a + 49'(8 * i)) & 49'h3F);
    return a + 49'(8 * i);
  endfunction

  // memory contents seen by the slave: word k of the line is seed ^ k
  function automatic logic [63:0] mem_word(input logic [48:0] a, input logic [63:0] seed);
    return seed ^ 64'(a[5:3]);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic do_refill(input logic [48:0] addr, input logic [63:0] seed,
                           input int bad_beat, input int last_beat,
                           input logic [5:0] rid_val, input int max_wait);
    logic [511:0] exp_line;
    logic         exp_err;
    logic [48:0]  ar_a;
    logic [2:0]   ar_b;
    int           guard;
    int           d;
    exp_err = (bad_beat >= 0) || (last_beat != 7) || (rid_val != 6'd0);
    for (int i = 0; i < 8; i++) exp_line[64*i +: 64] = seed ^ 64'(i);

    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL rd_req_ready got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = {8{rnd64()}};
    @(posedge ACLK); @(negedge ACLK);
    req_valid = 1'b0;

    guard = 0;
    while (axi.arvalid !== 1'b1 && guard < 20) begin @(negedge ACLK); guard++; end
    n_vec++;
    if (axi.arvalid !== 1'b1) begin
      n_err++; $display("FAIL rd_arvalid_timeout got=%b want=1", axi.arvalid);
    end
    n_vec++;
    if (axi.araddr !== exp_araddr(addr)) begin
      n_err++; $display("FAIL rd_araddr got=%h want=%h", axi.araddr, exp_araddr(addr));
    end
    n_vec++;
    if (axi.arburst !== exp_arburst() || axi.arlen !== 8'd7) begin
      n_err++; $display("FAIL rd_arburst_len got=%b/%0d want=%b/7", axi.arburst, axi.arlen, exp_arburst());
    end
    n_vec++;
    if ({axi.arsize, axi.arlock, axi.arprot, axi.arqos, axi.aruser, axi.arid, axi.arcache} !==
        {3'b011, 1'b0, 3'b000, 4'b0000, 1'b0, 6'd0, 4'b0011}) begin
      n_err++; $display("FAIL rd_ar_const got size=%b id=%0d cache=%b want size=011 id=0 cache=0011",
                        axi.arsize, axi.arid, axi.arcache);
    end
    ar_a = axi.araddr; ar_b = axi.arburst;

    d = $urandom_range(0, max_wait);
    repeat (d) begin
      @(negedge ACLK);
      n_vec++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== ar_a) begin
        n_err++; $display("FAIL rd_ar_stable got=%b/%h want=1/%h", axi.arvalid, axi.araddr, ar_a);
      end
    end
    axi.arready = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    axi.arready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, max_wait);
      repeat (d) begin axi.rvalid = 1'b0; @(negedge ACLK); end
      axi.rvalid = 1'b1;
      axi.rdata  = mem_word(beat_addr(ar_a, ar_b, i), seed);
      axi.rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      axi.rlast  = (i == last_beat);
      axi.rid    = rid_val;
      n_vec++;
      if (axi.rready !== 1'b1) begin
        n_err++; $display("FAIL rd_rready beat=%0d got=%b want=1", i, axi.rready);
      end
      @(posedge ACLK); @(negedge ACLK);
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; axi.rid = 6'd0;

    n_vec++;
    if (resp_valid !== 1'b1) begin
      n_err++; $display("FAIL rd_resp_valid got=%b want=1", resp_valid);
    end
    n_vec++;
    if (resp_err !== exp_err) begin
      n_err++; $display("FAIL rd_resp_err got=%b want=%b", resp_err, exp_err);
    end
    n_vec++;
    if (resp_rdata !== exp_line) begin
      n_err++; $display("FAIL rd_line got=%h want=%h", resp_rdata, exp_line);
    end
    @(negedge ACLK);
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rd_after_done got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic do_writeback(input logic [48:0] addr, input logic [511:0] line,
                              input int aw_hold, input int max_wait,
                              input logic [5:0] bid_val, input logic [1:0] bresp_val);
    logic exp_err;
    logic wr, ar;
    int   wn, awn, guard, post, d;
    exp_err = (bid_val != 6'd0) || (bresp_val != 2'b00);

    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_req_ready got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = line;
    @(posedge ACLK); @(negedge ACLK);
    req_valid = 1'b0; req_wdata = '0;

    wn = 0; awn = 0; guard = 0; post = 0;
    while ((wn < 8 || awn < 1) && guard < 200) begin
      if (wn == 8) post++;
      wr = (max_wait == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (aw_hold >= 0) ar = (wn == 8) && (post > aw_hold);
      else              ar = (max_wait == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      axi.wready = wr; axi.awready = ar;
      if (wn == 8 && axi.wvalid === 1'b1) begin
        n_vec++; n_err++; $display("FAIL wr_extra_beat got wvalid=1 want=0");
      end
      if (aw_hold >= 0 && wn == 8 && awn == 0) begin
        n_vec++;
        if (axi.awvalid !== 1'b1) begin
          n_err++; $display("FAIL wr_aw_held got=%b want=1", axi.awvalid);
        end
      end
      if (axi.wvalid === 1'b1 && wr && wn < 8) begin
        n_vec++;
        if (axi.wdata !== line[64*wn +: 64] || axi.wstrb !== 8'hFF) begin
          n_err++; $display("FAIL wr_wdata beat=%0d got=%h/%h want=%h/ff", wn, axi.wdata, axi.wstrb, line[64*wn +: 64]);
        end
        n_vec++;
        if (axi.wlast !== (wn == 7)) begin
          n_err++; $display("FAIL wr_wlast beat=%0d got=%b want=%b", wn, axi.wlast, (wn == 7));
        end
        wn++;
      end
      if (axi.awvalid === 1'b1 && ar) begin
        n_vec++;
        if (awn != 0) begin
          n_err++; $display("FAIL wr_aw_twice got=%0d want=0", awn);
        end
        n_vec++;
        if (axi.awaddr !== (addr & ~49'h3F) || axi.awburst !== 3'b001 || axi.awlen !== 8'd7 ||
            axi.awsize !== 3'b011 || axi.awid !== 6'd0 || axi.awcache !== 4'b0011) begin
          n_err++; $display("FAIL wr_aw got addr=%h burst=%b len=%0d want addr=%h burst=001 len=7",
                            axi.awaddr, axi.awburst, axi.awlen, addr & ~49'h3F);
        end
        awn++;
      end
      @(posedge ACLK); @(negedge ACLK);
      guard++;
    end
    axi.wready = 1'b0; axi.awready = 1'b0;
    n_vec++;
    if (wn != 8 || awn != 1) begin
      n_err++; $display("FAIL wr_xfer_timeout got w=%0d aw=%0d want 8/1", wn, awn);
    end

    d = $urandom_range(0, max_wait);
    repeat (d) @(negedge ACLK);
    axi.bvalid = 1'b1; axi.bid = bid_val; axi.bresp = bresp_val;
    n_vec++;
    if (axi.bready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL wr_bready got=%b resp_valid=%b want 1/0", axi.bready, resp_valid);
    end
    @(posedge ACLK); @(negedge ACLK);
    axi.bvalid = 1'b0; axi.bid = 6'd0; axi.bresp = 2'b00;
    n_vec++;
    if (resp_valid !== 1'b1 || resp_err !== exp_err) begin
      n_err++; $display("FAIL wr_resp got valid=%b err=%b want 1/%b", resp_valid, resp_err, exp_err);
    end
    @(negedge ACLK);
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_after_done got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    n_vec++;
    if ({req_ready, resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 8'b0) begin
      n_err++; $display("FAIL reset_outputs got=%b want=00000000",
                        {req_ready, resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
    end
    n_vec++;
    if (resp_rdata !== 512'd0) begin
      n_err++; $display("FAIL reset_rdata got=%h want=0", resp_rdata);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_refill_basic();
    do_refill(49'h1_0000_0040, 64'd0, -1, 7, 6'd0, 0);
  endtask

  task automatic test_writeback_aw_late();
    logic [511:0] line;
    for (int i = 0; i < 8; i++) line[64*i +: 64] = 64'hA0 + 64'(i);
    do_writeback(49'h80, line, 5, 0, 6'd0, 2'b00);
  endtask

  task automatic test_refill_errors();
    do_refill(49'h0_1234_5680, rnd64(), 3, 6, 6'd0, 0);
    do_refill(49'h0_0000_1000, rnd64(), -1, 7, 6'd9, 1);
  endtask

  task automatic test_back_to_back();
    logic [511:0] line;
    for (int i = 0; i < 8; i++) line[64*i +: 64] = rnd64();
    do_writeback(49'h0_0000_2040, line, -1, 0, 6'd5, 2'b00);
    do_refill(49'h0_0000_2040, rnd64(), -1, 7, 6'd0, 0);
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] seed;
    seed = rnd64();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 49'h0_0000_3000;
    @(posedge ACLK); @(negedge ACLK);
    req_valid = 1'b0;
    axi.arready = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    axi.arready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      axi.rvalid = 1'b1; axi.rdata = seed ^ 64'(i); axi.rresp = 2'b00; axi.rid = 6'd0; axi.rlast = 1'b0;
      @(posedge ACLK); @(negedge ACLK);
    end
    n_vec++;
    if (axi.rready !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_rready got=%b want=1", axi.rready);
    end
    #2 ARESETn = 1'b0;
    #1;
    n_vec++;
    if ({axi.arvalid, axi.rready, resp_valid, req_ready, resp_err} !== 5'b0) begin
      n_err++; $display("FAIL rst_async_drop got=%b want=00000",
                        {axi.arvalid, axi.rready, resp_valid, req_ready, resp_err});
    end
    n_vec++;
    if (resp_rdata !== 512'd0) begin
      n_err++; $display("FAIL rst_rdata got=%h want=0", resp_rdata);
    end
    axi.rvalid = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    n_vec++;
    if (req_ready !== 1'b1 || axi.rready !== 1'b0) begin
      n_err++; $display("FAIL rst_release got ready=%b rready=%b want 1/0", req_ready, axi.rready);
    end
  endtask

  task automatic test_critical_word();
    // word 5 of the line requested; with critical-word-first beat 0 fills slot 5
    do_refill(49'h1_2345_6768, rnd64(), -1, 7, 6'd0, 0);
    do_refill(49'h0_0000_0078, 64'd0, -1, 7, 6'd0, 2);
  endtask

  task automatic test_random();
    logic [511:0] line;
    logic [48:0]  a;
    for (int n = 0; n < 24; n++) begin
      a = 49'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) line[64*i +: 64] = rnd64();
        do_writeback(a, line, -1, 2,
                     ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                     ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end else begin
        do_refill(a, rnd64(),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1,
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : 7,
                  ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                  2);
      end
    end
  endtask

  initial begin
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = 6'd0;
    axi.bvalid = 1'b0; axi.bid = 6'd0; axi.bresp = 2'b00;
    test_reset();
    test_refill_basic();
    test_writeback_aw_late();
    test_refill_errors();
    test_back_to_back();
    test_reset_mid_burst();
    test_critical_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
